fetch_stall_queue: RTL and testbench

//  Instruction-fetch front end that consumes the hazard unit's stall controls (PCWrite, DWrite) and branch flush.

---
 rtl/fetch_stall_queue_pkg.sv | 18 +
 rtl/fetch_stall_queue_if.sv | 36 +++
 rtl/fetch_stall_queue_sync_fifo.sv | 65 ++++++
 rtl/fetch_stall_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_stall_queue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stall_queue_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   PC_WIDTH      default PC / address width
//   INSTR_BYTES   byte stride between sequential instructions
//   NOP           canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t one buffered fetch: the PC it came from and the word returned
package fetch_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // The instruction FIFO stores entries packed as {pc, instr}, the same layout as this struct.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stall_queue_if.sv
// fetch_stall_queue_if: request/response channel between the fetch unit and instruction memory.
//   imem_req_valid  fetch -> mem   request valid
//   imem_req_ready  mem -> fetch   request accepted this cycle
//   imem_addr       fetch -> mem   request address
//   imem_rsp_valid  mem -> fetch   response valid (in request order)
//   imem_rsp_data   mem -> fetch   instruction word
// master = fetch unit side, slave = memory side.
interface fetch_stall_queue_if
  import fetch_pkg::*;
#(
  parameter int N = PC_WIDTH
);

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [N-1:0] imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_stall_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   clear  empties the FIFO this cycle (wins over push/pop)
//   push   write wdata at the tail (accepted when not full, or when full and popping)
//   wdata  data to write
//   pop    advance the head (ignored when empty)
//   rdata  current head entry
//   full   count == DEPTH
//   empty  count == 0
//   count  number of valid entries (clog2(DEPTH)+1 bits)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rdata = mem[rd_ptr];

  // A full FIFO may still take a push in the same cycle its head is popped.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  // Pointers are PTR_W bits wide, so with a power-of-2 DEPTH they wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stall_queue.sv
// fetch_stall_queue: instruction-fetch front end with hazard stall and branch-flush handling.
// Issues in-order requests to instruction memory, buffers returned words and drives the IF/ID register.
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   PCWrite        1 = fetch may advance PC, 0 = hold PC and issue nothing
//   DWrite         1 = IF/ID may load, 0 = IF/ID holds
//   flush          taken branch: redirect fetch to branch_target, discard everything in flight
//   branch_target  redirect address, valid with flush
//   imem           memory request/response channel (master side)
//   instr_D        IF/ID instruction
//   pc_D           IF/ID PC of instr_D
//   valid_D        IF/ID holds a real instruction (0 = bubble)
module fetch_stall_queue
  import fetch_pkg::*;
#(
  parameter int           N        = PC_WIDTH,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCWrite,
  input  logic                DWrite,
  input  logic                flush,
  input  logic [N-1:0]        branch_target,
  fetch_stall_queue_if.master imem,
  output logic [31:0]         instr_D,
  output logic [N-1:0]        pc_D,
  output logic                valid_D
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [N-1:0]     pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   in_use;
  logic             credit;
  logic             issue;
  logic             rsp;
  logic             keep_rsp;
  logic             pop;
  logic             tag_full;
  logic             tag_empty;
  logic             fifo_full;
  logic             fifo_empty;
  logic [N-1:0]     tag_pc;
  logic [N+31:0]    head;

  // Requests in flight plus words already buffered may never exceed DEPTH, so every
  // response is guaranteed a FIFO slot.
  assign in_use = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit = (in_use < (CNT_W+1)'(DEPTH));

  // Gated by reset so no request is presented while the unit is held in reset.
  assign imem.imem_req_valid = reset & PCWrite & ~flush & credit;
  assign imem.imem_addr      = pc;

  assign issue = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp   = imem.imem_rsp_valid;

  // A response is kept only if it belongs to the current fetch stream.
  assign keep_rsp = rsp & ~flush & (drop == '0);
  assign pop      = DWrite & ~flush & ~fifo_empty;

  // Tag FIFO: remembers the PC of each request in flight. Its occupancy is the
  // outstanding-request count. It is never cleared by flush because responses to
  // pre-flush requests still arrive and must retire their tags.
  sync_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .push  (issue),
    .wdata (pc),
    .pop   (rsp),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  // Instruction FIFO: entries packed {pc, instr}. A word pushed this cycle only
  // becomes the head next cycle, giving the 1-cycle minimum rsp -> valid_D latency.
  sync_fifo #(
    .WIDTH (N + 32),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (keep_rsp),
    .wdata ({tag_pc, imem.imem_rsp_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // PC: redirect on flush, otherwise step one instruction per accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= branch_target;
    end else if (issue) begin
      pc <= pc + N'(INSTR_BYTES);
    end
  end

  // Drop counter: on flush every request still in flight after this cycle's response
  // becomes stale. Nothing issues in a flush cycle, so that is outstanding minus rsp.
  // Since stale requests are a subset of outstanding, drop stays within DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop <= '0;
    end else if (flush) begin
      drop <= outstanding - CNT_W'(rsp);
    end else if (rsp && (drop != '0)) begin
      drop <= drop - 1'b1;
    end
  end

  // IF/ID register: bubble on flush or when nothing is buffered; data holds on a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_D <= '0;
      pc_D    <= '0;
      valid_D <= 1'b0;
    end else if (flush) begin
      valid_D <= 1'b0;
    end else if (DWrite) begin
      if (!fifo_empty) begin
        pc_D    <= head[N+31:32];
        instr_D <= head[31:0];
        valid_D <= 1'b1;
      end else begin
        valid_D <= 1'b0;
      end
    end
  end

  rsp_needs_request: assert property (@(posedge clk) disable iff (!reset) rsp |-> !tag_empty);
  issue_has_tag_slot: assert property (@(posedge clk) disable iff (!reset) issue |-> !tag_full);
  push_has_fifo_slot: assert property (@(posedge clk) disable iff (!reset) keep_rsp |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_stall_queue.sv
// tb_fetch_stall_queue: directed self-checking bench for fetch_stall_queue.
// Includes an in-order instruction memory model with adjustable latency.
module tb_fetch_stall_queue;

  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         PCWrite;
  logic         DWrite;
  logic         flush;
  logic [N-1:0] branch_target;
  logic [31:0]  instr_D;
  logic [N-1:0] pc_D;
  logic         valid_D;

  int errors = 0;
  int checks = 0;

  fetch_stall_queue_if #(.N(N)) imem ();

  fetch_stall_queue #(
    .N        (N),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PCWrite       (PCWrite),
    .DWrite        (DWrite),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (imem),
    .instr_D       (instr_D),
    .pc_D          (pc_D),
    .valid_D       (valid_D)
  );

  always #5 clk = ~clk;

  // Word stored at each address in the memory model.
  function automatic logic [31:0] memWord(input logic [N-1:0] a);
    return 32'hA000_0000 ^ a[31:0];
  endfunction

  // Memory model: handshake sampled mid-cycle, response queued with due cycle, driven #1 after an edge.
  typedef struct {
    int           due;
    logic [N-1:0] addr;
  } pend_t;

  pend_t        pend[$];
  int           lat = 1;
  int           cyc = 0;
  logic         fire_q = 1'b0;
  logic [N-1:0] addr_q = '0;

  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
  end

  always @(negedge clk) begin
    fire_q = reset & imem.imem_req_valid & imem.imem_req_ready;
    addr_q = imem.imem_addr;
  end

  always @(posedge clk) begin
    pend_t e;
    #1;
    cyc++;
    if (!reset) begin
      pend.delete();
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = '0;
    end else begin
      if (fire_q) begin
        e.due  = cyc + lat - 1;
        e.addr = addr_q;
        pend.push_back(e);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = memWord(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem.imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 2 time units after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int guard;
    reset         = 1'b0;
    PCWrite       = 1'b1;
    DWrite        = 1'b1;
    flush         = 1'b0;
    branch_target = '0;
    imem.imem_req_ready = 1'b1;

    // Reset state
    repeat (3) applyStimulus();
    #1;
    checkOutput("rst_valid_D", 64'(valid_D), 64'd0);
    checkOutput("rst_instr_D", 64'(instr_D), 64'd0);
    checkOutput("rst_pc_D", pc_D, 64'd0);
    checkOutput("rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("t1_req_valid", 64'(imem.imem_req_valid), 64'd1);
    checkOutput("t1_addr0", imem.imem_addr, 64'd0);

    // Streaming with 1-cycle memory: first instruction appears on the third edge
    for (int k = 1; k <= 6; k++) begin
      applyStimulus();
      checkOutput("t1_addr", imem.imem_addr, 64'(4 * k));
      if (k >= 3) begin
        checkOutput("t1_valid_D", 64'(valid_D), 64'd1);
        checkOutput("t1_pc_D", pc_D, 64'(4 * (k - 3)));
        checkOutput("t1_instr_D", 64'(instr_D), 64'(memWord(64'(4 * (k - 3)))));
      end else begin
        checkOutput("t1_bubble", 64'(valid_D), 64'd0);
      end
    end

    // Decode stall: IF/ID frozen, fetch fills the buffer then stops
    DWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("t2_pc_D_frozen", pc_D, 64'd12);
      checkOutput("t2_instr_D_frozen", 64'(instr_D), 64'(memWord(64'd12)));
      checkOutput("t2_valid_D", 64'(valid_D), 64'd1);
    end
    #1;
    checkOutput("t2_credit_stop", 64'(imem.imem_req_valid), 64'd0);
    checkOutput("t2_pc_held", imem.imem_addr, 64'd32);
    DWrite = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus();
      checkOutput("t2_release_pc_D", pc_D, 64'(16 + 4 * i));
      checkOutput("t2_release_instr", 64'(instr_D), 64'(memWord(64'(16 + 4 * i))));
    end

    // Fetch stall: no requests, buffer drains, then bubbles
    PCWrite = 1'b0;
    #1;
    checkOutput("t3_no_req", 64'(imem.imem_req_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t3_drain_pc_D", pc_D, 64'(44 + 4 * i));
      checkOutput("t3_drain_valid", 64'(valid_D), 64'd1);
    end
    applyStimulus();
    checkOutput("t3_empty_valid", 64'(valid_D), 64'd0);
    checkOutput("t3_empty_pc_hold", pc_D, 64'd52);
    checkOutput("t3_addr_hold", imem.imem_addr, 64'd56);

    // Latency 3, two requests in flight, then redirect to 0x100
    lat     = 3;
    PCWrite = 1'b1;
    applyStimulus();
    applyStimulus();
    flush         = 1'b1;
    branch_target = 64'h100;
    #1;
    checkOutput("t4_flush_no_req", 64'(imem.imem_req_valid), 64'd0);
    applyStimulus();
    flush = 1'b0;
    checkOutput("t4_flush_valid", 64'(valid_D), 64'd0);
    checkOutput("t4_redirect_addr", imem.imem_addr, 64'h100);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("t4_stale_dropped", 64'(valid_D), 64'd0);
    end
    applyStimulus();
    checkOutput("t4_target_valid", 64'(valid_D), 64'd1);
    checkOutput("t4_target_pc_D", pc_D, 64'h100);
    checkOutput("t4_target_instr", 64'(instr_D), 64'(memWord(64'h100)));

    // Flush in the same cycle as a decode stall and an arriving response
    guard = 0;
    while (!imem.imem_rsp_valid && guard < 10) begin
      applyStimulus();
      guard++;
    end
    checkOutput("t5_rsp_present", 64'(imem.imem_rsp_valid), 64'd1);
    checkOutput("t5_pre_valid", 64'(valid_D), 64'd1);
    flush         = 1'b1;
    DWrite        = 1'b0;
    branch_target = 64'h200;
    applyStimulus();
    flush  = 1'b0;
    checkOutput("t5_flush_wins_valid", 64'(valid_D), 64'd0);
    checkOutput("t5_redirect_addr", imem.imem_addr, 64'h200);
    DWrite = 1'b1;
    guard  = 0;
    while (!valid_D && guard < 20) begin
      applyStimulus();
      guard++;
    end
    checkOutput("t5_resume_valid", 64'(valid_D), 64'd1);
    checkOutput("t5_first_pc_D", pc_D, 64'h200);
    checkOutput("t5_first_instr", 64'(instr_D), 64'(memWord(64'h200)));

    // Fill the buffer, then reset asynchronously mid-stream
    lat    = 1;
    DWrite = 1'b0;
    repeat (10) applyStimulus();
    #1;
    checkOutput("t6_full_no_req", 64'(imem.imem_req_valid), 64'd0);
    checkOutput("t6_full_valid", 64'(valid_D), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(valid_D), 64'd0);
    checkOutput("t6_async_pc_D", pc_D, 64'd0);
    checkOutput("t6_async_instr", 64'(instr_D), 64'd0);
    checkOutput("t6_async_req", 64'(imem.imem_req_valid), 64'd0);
    checkOutput("t6_async_addr", imem.imem_addr, 64'd0);
    DWrite = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("t6_restart_addr", imem.imem_addr, 64'd4);
    checkOutput("t6_restart_bubble", 64'(valid_D), 64'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("t6_restart_valid", 64'(valid_D), 64'd1);
    checkOutput("t6_restart_pc_D", pc_D, 64'd0);
    checkOutput("t6_restart_instr", 64'(instr_D), 64'(memWord(64'd0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
